multiplexer_n_to_1_reg: RTL and testbench



---
 rtl/multiplexer_n_to_1_reg.sv | 104 ++++++++++
 tb/tb_multiplexer_n_to_1_reg.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/multiplexer_n_to_1_reg.sv
// Registered N:1 multiplexer of W-bit channels with a valid/ready output handshake.
// Define MUXN_SCAN_EN to build the round-robin scan pointer and honour MODE.
module multiplexer_n_to_1_reg #(
   parameter int unsigned W = 1,
   parameter int unsigned N = 4,
   localparam int unsigned SW = $clog2(N)
) (
   input  logic            CLK,
   input  logic            RST_N,
   input  logic [N*W-1:0]  D,
   input  logic [SW-1:0]   S,
   input  logic            MODE,
   input  logic            REQ,
   output logic [W-1:0]    Y,
   output logic [SW-1:0]   Y_CH,
   output logic            Y_ERR,
   output logic            Y_VALID,
   input  logic            Y_READY
);

   logic          cap;
   logic [SW-1:0] sel;
   logic          sel_oor;
   logic [W-1:0]  sel_data;

   logic [W-1:0]  y_q, y_d;
   logic [SW-1:0] ch_q, ch_d;
   logic          err_q, err_d;
   logic          valid_q, valid_d;

   // A held sample blocks new captures until the consumer takes it.
   assign cap = REQ && (!valid_q || Y_READY);

`ifdef MUXN_SCAN_EN
   logic [SW-1:0] p_q, p_d;

   always_comb begin
      sel = MODE ? p_q : S;
      p_d = p_q;
      if (cap && MODE) begin
         p_d = (p_q == SW'(N - 1)) ? '0 : p_q + 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         p_q <= '0;
      end else begin
         p_q <= p_d;
      end
   end
`else
   logic unused_mode;
   assign unused_mode = MODE;
   assign sel         = S;
`endif

   // Only reachable with a non-power-of-two N in direct mode.
   assign sel_oor = (32'(sel) >= N);

   always_comb begin
      sel_data = '0;
      for (int unsigned k = 0; k < N; k++) begin
         if (32'(sel) == k) begin
            sel_data = D[k*W +: W];
         end
      end
   end

   always_comb begin
      y_d     = y_q;
      ch_d    = ch_q;
      err_d   = err_q;
      valid_d = valid_q;
      if (cap) begin
         y_d     = sel_data;
         ch_d    = sel;
         err_d   = sel_oor;
         valid_d = 1'b1;
      end else if (valid_q && Y_READY) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         y_q     <= '0;
         ch_q    <= '0;
         err_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         y_q     <= y_d;
         ch_q    <= ch_d;
         err_q   <= err_d;
         valid_q <= valid_d;
      end
   end

   assign Y       = y_q;
   assign Y_CH    = ch_q;
   assign Y_ERR   = err_q;
   assign Y_VALID = valid_q;

endmodule

// File: tb/tb_multiplexer_n_to_1_reg.sv
// Scoreboard bench for multiplexer_n_to_1_reg (N=3, W=8); the reference model
// follows MUXN_SCAN_EN so either build is checked against its own behaviour.
module tb_multiplexer_n_to_1_reg;

   localparam int unsigned W  = 8;
   localparam int unsigned N  = 3;
   localparam int unsigned SW = 2;
`ifdef MUXN_SCAN_EN
   localparam bit ScanEn = 1'b1;
`else
   localparam bit ScanEn = 1'b0;
`endif

   typedef struct packed {
      logic [W-1:0]  y;
      logic [SW-1:0] ch;
      logic          err;
   } exp_t;

   logic          clk;
   logic          rst_n;
   logic [N*W-1:0] d;
   logic [SW-1:0] s;
   logic          mode;
   logic          req;
   logic [W-1:0]  y;
   logic [SW-1:0] y_ch;
   logic          y_err;
   logic          y_valid;
   logic          y_ready;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state
   exp_t  q[$];
   bit    m_valid;
   int    m_p;
   exp_t  m_held;

   multiplexer_n_to_1_reg #(.W(W), .N(N)) dut (
      .CLK     (clk),
      .RST_N   (rst_n),
      .D       (d),
      .S       (s),
      .MODE    (mode),
      .REQ     (req),
      .Y       (y),
      .Y_CH    (y_ch),
      .Y_ERR   (y_err),
      .Y_VALID (y_valid),
      .Y_READY (y_ready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_valid = 1'b0;
      m_p     = 0;
      m_held  = '0;
   endtask

   // One clock with the current inputs; model updates right after the edge.
   task automatic cyc();
      bit   cap;
      int   c;
      exp_t e;
      cap = req && (!m_valid || y_ready);
      @(posedge clk);
      if (cap) begin
         c = (ScanEn && mode) ? m_p : int'(s);
         e.ch = c[SW-1:0];
         if (c >= N) begin
            e.y   = '0;
            e.err = 1'b1;
         end else begin
            e.y   = d[c*W +: W];
            e.err = 1'b0;
         end
         if (ScanEn && mode) m_p = (m_p + 1) % N;
         q.push_back(e);
         m_held  = e;
         m_valid = 1'b1;
      end else if (m_valid && y_ready) begin
         m_valid = 1'b0;
      end
      #1;
   endtask

   // Monitor: compares presented samples, pops on consumption.
   always @(negedge clk) begin
      exp_t e;
      chk("y_valid", {31'd0, y_valid}, {31'd0, m_valid});
      if (m_valid) begin
         if (q.size() == 0) begin
            chk("sb_entries", 32'd0, 32'd1);
         end else begin
            e = q[0];
            chk("y", {24'd0, y}, {24'd0, e.y});
            chk("y_ch", {30'd0, y_ch}, {30'd0, e.ch});
            chk("y_err", {31'd0, y_err}, {31'd0, e.err});
            if (y_ready) void'(q.pop_front());
         end
      end else begin
         chk("hold_y", {24'd0, y}, {24'd0, m_held.y});
         chk("hold_ch", {30'd0, y_ch}, {30'd0, m_held.ch});
         chk("hold_err", {31'd0, y_err}, {31'd0, m_held.err});
      end
   end

   initial begin
      model_reset();
      rst_n   = 1'b0;
      d       = '1;
      s       = '0;
      mode    = 1'b0;
      req     = 1'b0;
      y_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Idle after reset
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("idle_y", {24'd0, y}, 32'd0);
         chk("idle_ch", {30'd0, y_ch}, 32'd0);
      end

      // Direct select
      d   = {8'h33, 8'h22, 8'h11};
      req = 1'b1;
      for (int i = 0; i < N; i++) begin
         s = SW'(i);
         cyc();
      end

      // Stall and hold, then release
      s = 2'd2;
      cyc();
      y_ready = 1'b0;
      s       = 2'd1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("stall_y", {24'd0, y}, 32'h33);
      end
      y_ready = 1'b1;
      cyc();
      chk("release_y", {24'd0, y}, 32'h22);

      // Scan wrap, direct interlude, resume
      mode = 1'b1;
      repeat (7) cyc();
      mode = 1'b0;
      s    = 2'd1;
      cyc();
      mode = 1'b1;
      cyc();

      // Out-of-range select, then recovery
      mode = 1'b0;
      s    = 2'd3;
      cyc();
      chk("oor_err", {31'd0, y_err}, 32'd1);
      s = 2'd0;
      cyc();
      chk("oor_clear_y", {24'd0, y}, 32'h11);

      // Data changes without a capture
      req = 1'b0;
      cyc();
      d = {8'hAA, 8'hBB, 8'hCC};
      repeat (3) cyc();

      // Randomised traffic
      for (int i = 0; i < 400; i++) begin
         d       = {$urandom, $urandom};
         s       = SW'($urandom_range(0, 3));
         mode    = 1'($urandom_range(0, 1));
         req     = ($urandom_range(0, 3) != 0);
         y_ready = ($urandom_range(0, 2) != 0);
         cyc();
      end

      // Reset in the middle of a stall
      req     = 1'b1;
      y_ready = 1'b0;
      s       = 2'd2;
      mode    = 1'b0;
      d       = {8'h33, 8'h22, 8'h11};
      cyc();
      cyc();
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      chk("rst_valid", {31'd0, y_valid}, 32'd0);
      chk("rst_y", {24'd0, y}, 32'd0);
      req = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      y_ready = 1'b1;
      mode    = 1'b1;
      req     = 1'b1;
      repeat (4) cyc();
      req = 1'b0;
      repeat (2) cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
